// File: rtl/btn_event_pkg.sv
// Shared definitions for the button event block.
// Contents:
//   btn_state_t  - FSM state encoding (IDLE / DOWN / REPEAT)
//   clog2        - bit width needed to hold values 0..v-1 (minimum 1)
//   max_int      - larger of two integers, used to size the shared timer
package btn_event_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DOWN   = 2'd1,
    ST_REPEAT = 2'd2
  } btn_state_t;

  // Width that can represent every value 0..v-1.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'd1 << i) < 32'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_event_cycle_timer.sv
// Up-counter with synchronous clear and a programmable terminal count.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clr       - clear count to 0 (wins over inc)
//   inc       - advance count by one
//   tc_val    - terminal count value compared against the current count
//   tc        - high while count == tc_val
// The owner clears the counter on terminal count, so it never wraps.
module cycle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] tc_val,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + W'(1);
    end
  end

  assign tc = (count == tc_val);

endmodule

// File: rtl/btn_event.sv
// Converts a debounced button level into single-cycle event pulses.
// Ports:
//   clk, rst       - clock, asynchronous active-high reset
//   btn_db         - debounced button level, synchronous to clk
//   en             - event enable; low forces IDLE and suppresses pulses
//   press          - pulse on a recognised 0->1 transition
//   release_pulse  - pulse when the button is let go while DOWN or REPEAT
//   long_press     - pulse when the hold reaches LONG_CYCLES edges
//   repeat_pulse   - pulse every REPEAT_CYCLES edges after long_press
//   held           - level, high while DOWN or REPEAT
//   state          - current FSM state, for observation
// All outputs are registered.
module btn_event
  import btn_event_pkg::*;
#(
  parameter int LONG_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_db,
  input  logic       en,
  output logic       press,
  output logic       release_pulse,
  output logic       long_press,
  output logic       repeat_pulse,
  output logic       held,
  output btn_state_t state
);

  localparam int CNT_W = clog2(max_int(LONG_CYCLES, REPEAT_CYCLES));
  localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYCLES - 1);

  btn_state_t       next_state;
  logic             prev;
  logic             timer_clr;
  logic             timer_inc;
  logic             timer_tc;
  logic [CNT_W-1:0] tc_val;
  logic             press_d;
  logic             release_d;
  logic             long_d;
  logic             repeat_d;

  // One timer serves both phases; its terminal count follows the state.
  assign tc_val = (state == ST_DOWN) ? LONG_TC : REPEAT_TC;

  cycle_timer #(
    .W(CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (timer_clr),
    .inc    (timer_inc),
    .tc_val (tc_val),
    .tc     (timer_tc)
  );

  // Release is checked before terminal count so it wins on a collision.
  always_comb begin
    next_state = state;
    timer_clr  = 1'b0;
    timer_inc  = 1'b0;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
    repeat_d   = 1'b0;
    if (!en) begin
      next_state = ST_IDLE;
      timer_clr  = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          timer_clr = 1'b1;
          if (btn_db && !prev) begin
            next_state = ST_DOWN;
            press_d    = 1'b1;
          end
        end
        ST_DOWN: begin
          if (!btn_db) begin
            next_state = ST_IDLE;
            release_d  = 1'b1;
            timer_clr  = 1'b1;
          end else if (timer_tc) begin
            next_state = ST_REPEAT;
            long_d     = 1'b1;
            timer_clr  = 1'b1;
          end else begin
            timer_inc = 1'b1;
          end
        end
        ST_REPEAT: begin
          if (!btn_db) begin
            next_state = ST_IDLE;
            release_d  = 1'b1;
            timer_clr  = 1'b1;
          end else if (timer_tc) begin
            repeat_d  = 1'b1;
            timer_clr = 1'b1;
          end else begin
            timer_inc = 1'b1;
          end
        end
        default: begin
          next_state = ST_IDLE;
          timer_clr  = 1'b1;
        end
      endcase
    end
  end

  // prev resets (and is held) at 1 so a press always needs a fresh 0->1
  // edge after reset or after enable returns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      prev          <= 1'b1;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
    end else begin
      state         <= next_state;
      prev          <= en ? btn_db : 1'b1;
      press         <= press_d;
      release_pulse <= release_d;
      long_press    <= long_d;
      repeat_pulse  <= repeat_d;
      held          <= (next_state != ST_IDLE);
    end
  end

endmodule
